// File: rtl/vga_capture_if.sv
// Capture-side VGA bundle: sampled video inputs plus the recovered pixel stream and status.
// master drives video and observes results; slave is the capture block.
interface vga_capture_if;
  logic        pixel_en;
  logic        hsync_i;
  logic        vsync_i;
  logic [3:0]  red_i;
  logic [3:0]  green_i;
  logic [3:0]  blue_i;
  logic        pixel_valid;
  logic [11:0] pixel_data;
  logic [9:0]  pixel_x;
  logic [8:0]  pixel_y;
  logic        frame_done;
  logic [15:0] frame_crc;
  logic        locked;
  logic        timing_err;

  modport master (
    output pixel_en, hsync_i, vsync_i, red_i, green_i, blue_i,
    input  pixel_valid, pixel_data, pixel_x, pixel_y, frame_done, frame_crc, locked, timing_err
  );

  modport slave (
    input  pixel_en, hsync_i, vsync_i, red_i, green_i, blue_i,
    output pixel_valid, pixel_data, pixel_x, pixel_y, frame_done, frame_crc, locked, timing_err
  );
endinterface

// File: rtl/vga_capture.sv
// VGA receive side: recovers x/y from sampled syncs, checks line/frame timing, streams
// visible pixels once locked and produces a CRC-16-CCITT over every completed frame.
module vga_capture #(
  parameter int unsigned H_VISIBLE       = 640,
  parameter int unsigned H_FRONT         = 16,
  parameter int unsigned H_SYNC          = 96,
  parameter int unsigned H_BACK          = 48,
  parameter int unsigned V_VISIBLE       = 480,
  parameter int unsigned V_FRONT         = 10,
  parameter int unsigned V_SYNC          = 2,
  parameter int unsigned V_BACK          = 33,
  parameter bit          SYNC_ACTIVE_LOW = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  vga_capture_if.slave  vif
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned H_START = H_SYNC + H_BACK;
  localparam int unsigned V_START = V_SYNC + V_BACK;

  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

  state_t      state_q, state_d;
  logic        hs_prev_q, hs_prev_d;
  logic        vs_prev_q, vs_prev_d;
  logic        vs_pend_q, vs_pend_d;
  logic [9:0]  h_count_q, h_count_d;
  logic [9:0]  v_count_q, v_count_d;
  logic [15:0] crc_q, crc_d;
  logic        pixel_valid_q, pixel_valid_d;
  logic [11:0] pixel_data_q, pixel_data_d;
  logic [9:0]  pixel_x_q, pixel_x_d;
  logic [8:0]  pixel_y_q, pixel_y_d;
  logic        last_q, last_d;
  logic        frame_done_q, frame_done_d;
  logic [15:0] frame_crc_q, frame_crc_d;
  logic        timing_err_q, timing_err_d;

  logic        hs_act, vs_act, hs_lead, vs_lead, frame_edge, line_bad, frame_bad;
  logic        h_vis, v_vis;
  logic [9:0]  y_full;
  logic [11:0] sample_pix;

  // Bit-serial CCITT step unrolled over the 12 pixel bits, MSB first.
  function automatic logic [15:0] crc12(input logic [15:0] c, input logic [11:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 11; i >= 0; i--) begin
      if (r[15] ^ d[i]) r = {r[14:0], 1'b0} ^ 16'h1021;
      else              r = {r[14:0], 1'b0};
    end
    return r;
  endfunction

  always_comb begin
    state_d       = state_q;
    hs_prev_d     = hs_prev_q;
    vs_prev_d     = vs_prev_q;
    vs_pend_d     = vs_pend_q;
    h_count_d     = h_count_q;
    v_count_d     = v_count_q;
    crc_d         = crc_q;
    pixel_valid_d = 1'b0;
    pixel_data_d  = pixel_data_q;
    pixel_x_d     = pixel_x_q;
    pixel_y_d     = pixel_y_q;
    last_d        = 1'b0;
    frame_done_d  = last_q;
    frame_crc_d   = frame_crc_q;
    timing_err_d  = timing_err_q;

    hs_act     = SYNC_ACTIVE_LOW ? ~vif.hsync_i : vif.hsync_i;
    vs_act     = SYNC_ACTIVE_LOW ? ~vif.vsync_i : vif.vsync_i;
    hs_lead    = hs_act & ~hs_prev_q;
    vs_lead    = vs_act & ~vs_prev_q;
    // A vsync edge is only acted on at the hsync edge that starts line 0.
    frame_edge = hs_lead & (vs_lead | vs_pend_q);
    line_bad   = hs_lead & (h_count_q != 10'(H_TOTAL - 1));
    frame_bad  = frame_edge & (v_count_q != 10'(V_TOTAL - 1));
    sample_pix = {vif.red_i, vif.blue_i, vif.green_i};
    h_vis      = 1'b0;
    v_vis      = 1'b0;
    y_full     = '0;

    if (vif.pixel_en) begin
      hs_prev_d = hs_act;
      vs_prev_d = vs_act;
      if (hs_lead) begin
        h_count_d = '0;
        vs_pend_d = 1'b0;
        if (frame_edge)              v_count_d = '0;
        else if (v_count_q != 10'h3FF) v_count_d = v_count_q + 10'd1;
      end else begin
        if (h_count_q != 10'h3FF) h_count_d = h_count_q + 10'd1;
        if (vs_lead)              vs_pend_d = 1'b1;
      end

      unique case (state_q)
        SEARCH:  if (frame_edge) state_d = MEASURE;
        MEASURE: begin
          if (line_bad || frame_bad) state_d = SEARCH;
          else if (frame_edge)       state_d = LOCKED;
        end
        LOCKED: begin
          if (line_bad || frame_bad) begin
            state_d      = SEARCH;
            timing_err_d = 1'b1;
          end
        end
        default: state_d = SEARCH;
      endcase

      h_vis  = (h_count_d >= 10'(H_START)) && (h_count_d < 10'(H_START + H_VISIBLE));
      v_vis  = (v_count_d >= 10'(V_START)) && (v_count_d < 10'(V_START + V_VISIBLE));
      y_full = v_count_d - 10'(V_START);
      if (state_q == LOCKED && h_vis && v_vis) begin
        pixel_valid_d = 1'b1;
        pixel_data_d  = sample_pix;
        pixel_x_d     = h_count_d - 10'(H_START);
        pixel_y_d     = y_full[8:0];
        crc_d         = crc12(crc_q, sample_pix);
        last_d        = (pixel_x_d == 10'(H_VISIBLE - 1)) && (pixel_y_d == 9'(V_VISIBLE - 1));
      end
    end

    if (last_q) begin
      frame_crc_d = crc_q;
      crc_d       = 16'hFFFF;
    end
    // Any partial frame is discarded: the running CRC only lives while locked.
    if (state_q != LOCKED) crc_d = 16'hFFFF;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= SEARCH;
      hs_prev_q     <= 1'b0;
      vs_prev_q     <= 1'b0;
      vs_pend_q     <= 1'b0;
      h_count_q     <= '0;
      v_count_q     <= '0;
      crc_q         <= 16'hFFFF;
      pixel_valid_q <= 1'b0;
      pixel_data_q  <= '0;
      pixel_x_q     <= '0;
      pixel_y_q     <= '0;
      last_q        <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_crc_q   <= '0;
      timing_err_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      hs_prev_q     <= hs_prev_d;
      vs_prev_q     <= vs_prev_d;
      vs_pend_q     <= vs_pend_d;
      h_count_q     <= h_count_d;
      v_count_q     <= v_count_d;
      crc_q         <= crc_d;
      pixel_valid_q <= pixel_valid_d;
      pixel_data_q  <= pixel_data_d;
      pixel_x_q     <= pixel_x_d;
      pixel_y_q     <= pixel_y_d;
      last_q        <= last_d;
      frame_done_q  <= frame_done_d;
      frame_crc_q   <= frame_crc_d;
      timing_err_q  <= timing_err_d;
    end
  end

  assign vif.pixel_valid = pixel_valid_q;
  assign vif.pixel_data  = pixel_data_q;
  assign vif.pixel_x     = pixel_x_q;
  assign vif.pixel_y     = pixel_y_q;
  assign vif.frame_done  = frame_done_q;
  assign vif.frame_crc   = frame_crc_q;
  assign vif.locked      = (state_q == LOCKED);
  assign vif.timing_err  = timing_err_q;

endmodule
